// File: rtl/mc_control_fsm.sv
// Main controller for the multi-cycle MIPS-subset datapath: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters (cycle_cnt, instr_cnt) are built when MC_PERF_CNT_EN is defined.
module mc_control_fsm #(
  parameter logic [1:0] RESET_PC_SEL = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        ext_zero,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JMP    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_q;
  state_t state_d;
  logic   in_reset;
  logic   illegal_q;
  logic   set_illegal;
  logic   imm_zext;
  logic   iex_zext;

  assign iex_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);

  // in_reset holds outputs idle for the cycle after reset, so the first fetch request
  // appears one cycle after rst is released; imm_zext keeps the IEX extender mode for IWB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      in_reset  <= 1'b1;
      illegal_q <= 1'b0;
      imm_zext  <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_reset <= 1'b0;
      if (set_illegal) illegal_q <= 1'b1;
      if (state_q == S_IEX) imm_zext <= iex_zext;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = RESET_PC_SEL;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    ext_zero    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    if (in_reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          pc_src    = 2'b00;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:                state_d = S_REX;
            OP_LW, OP_SW:            state_d = S_MEMADR;
            OP_BEQ:                  state_d = S_BEQ;
            OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEX;
            OP_J:                    state_d = S_JMP;
            default: begin
              state_d     = S_HALT;
              set_illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_write  = zero;
          state_d   = S_FETCH;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = iex_zext;
          alu_op    = iex_zext ? 2'b11 : 2'b00;
          state_d   = S_IWB;
        end
        S_IWB: begin
          reg_write = 1'b1;
          ext_zero  = imm_zext;
          alu_op    = imm_zext ? 2'b11 : 2'b00;
          state_d   = S_FETCH;
        end
        S_JMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_HALT;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MC_PERF_CNT_EN
  // An instruction retires whenever a non-fetch state hands control back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (!in_reset && (state_q != S_FETCH) && (state_d == S_FETCH))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: walks LW, SW, R-type, BEQ, ORI/ADDI, J,
// an illegal opcode, fetch wait states and reset during a store.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        ext_zero;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        illegal;
  logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  int tests_run;
  int tests_failed;

  mc_control_fsm #(.RESET_PC_SEL(2'b00)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_zero   (ext_zero),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .state      (state)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every control output so one comparison covers a whole state.
  logic [20:0] observed;
  assign observed = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     alu_src_a, alu_src_b, alu_op, ext_zero, reg_dst, mem_to_reg,
                     reg_write, illegal};

  function automatic logic [20:0] ctl(input int st, input int req, input int we, input int io,
                                      input int irw, input int pcw, input int pcs, input int asa,
                                      input int asb, input int aop, input int ez, input int rd,
                                      input int m2r, input int rw, input int ill);
    return {4'(st), 1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 2'(pcs), 1'(asa), 2'(asb),
            2'(aop), 1'(ez), 1'(rd), 1'(m2r), 1'(rw), 1'(ill)};
  endfunction

  task automatic applyStimulus(input logic r, input logic rdy, input logic z, input logic [5:0] op);
    rst       = r;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [20:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %06h expected %06h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h23);
    repeat (3) tick();
    checkOutput("reset_idle", ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));

    // Release reset: request stays low until the following edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h23);
    checkOutput("release_no_req", ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tick();
    checkOutput("lw_fetch", ctl(0,1,0,0,1,1,0,0,1,0,0,0,0,0,0));
    tick();
    checkOutput("lw_decode", ctl(1,0,0,0,0,0,0,0,3,0,0,0,0,0,0));
    tick();
    checkOutput("lw_memadr", ctl(2,0,0,0,0,0,0,1,2,0,0,0,0,0,0));
    tick();
    checkOutput("lw_memrd", ctl(3,1,0,1,0,0,0,0,0,0,0,0,0,0,0));
    tick();
    checkOutput("lw_memwb", ctl(4,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
    tick();

    // Fetch with three wait cycles, then BEQ taken.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h04);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fetch_wait", ctl(0,1,0,0,0,0,0,0,1,0,0,0,0,0,0));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h04);
    checkOutput("fetch_wait_done", ctl(0,1,0,0,1,1,0,0,1,0,0,0,0,0,0));
    tick();
    checkOutput("beq_decode", ctl(1,0,0,0,0,0,0,0,3,0,0,0,0,0,0));
    tick();
    checkOutput("beq_taken", ctl(8,0,0,0,0,1,1,1,0,1,0,0,0,0,0));
    tick();
    checkOutput("beq_return", ctl(0,1,0,0,1,1,0,0,1,0,0,0,0,0,0));
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h04);
    checkOutput("beq_not_taken", ctl(8,0,0,0,0,0,1,1,0,1,0,0,0,0,0));
    tick();

    // ORI: zero-extend, imm-logic op held into IWB even if opcode changes.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h0D);
    checkOutput("ori_fetch", ctl(0,1,0,0,1,1,0,0,1,0,0,0,0,0,0));
    tick();
    tick();
    checkOutput("ori_iex", ctl(9,0,0,0,0,0,0,1,2,3,1,0,0,0,0));
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h08);
    checkOutput("ori_iwb", ctl(10,0,0,0,0,0,0,0,0,3,1,0,0,1,0));
    tick();
    tick();
    tick();
    checkOutput("addi_iex", ctl(9,0,0,0,0,0,0,1,2,0,0,0,0,0,0));
    tick();
    checkOutput("addi_iwb", ctl(10,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    tick();

    // R-type.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00);
    tick();
    tick();
    checkOutput("r_rex", ctl(6,0,0,0,0,0,0,1,0,2,0,0,0,0,0));
    tick();
    checkOutput("r_rwb", ctl(7,0,0,0,0,0,0,0,0,0,0,1,0,1,0));
    tick();

    // Jump.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h02);
    tick();
    tick();
    checkOutput("j_jmp", ctl(11,0,0,0,0,1,2,0,0,0,0,0,0,0,0));
    tick();

    // SW with one memory wait cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h2B);
    tick();
    tick();
    checkOutput("sw_memadr", ctl(2,0,0,0,0,0,0,1,2,0,0,0,0,0,0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h2B);
    checkOutput("sw_memwr_wait", ctl(5,1,1,1,0,0,0,0,0,0,0,0,0,0,0));
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h2B);
    checkOutput("sw_memwr_done", ctl(5,1,1,1,0,0,0,0,0,0,0,0,0,0,0));
    tick();
    checkOutput("sw_return", ctl(0,1,0,0,1,1,0,0,1,0,0,0,0,0,0));

    // Illegal opcode halts with a sticky flag.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h3F);
    tick();
    checkOutput("ill_decode", ctl(1,0,0,0,0,0,0,0,3,0,0,0,0,0,0));
    tick();
    checkOutput("ill_halt", ctl(12,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h00);
    tick();
    tick();
    checkOutput("ill_halt_sticky", ctl(12,0,0,0,0,0,0,0,0,0,0,0,0,0,1));

    // Reset out of HALT, then reset in the middle of a store.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h2B);
    tick();
    checkOutput("halt_reset", ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h2B);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h2B);
    tick();
    checkOutput("sw2_memwr", ctl(5,1,1,1,0,0,0,0,0,0,0,0,0,0,0));
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h2B);
    tick();
    checkOutput("rst_mid_store", ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h2B);
    tick();
    checkOutput("post_rst_fetch", ctl(0,1,0,0,0,0,0,0,1,0,0,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
